// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; fixed latency regardless of operands.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, a_q;
  logic             sign_q_q, sign_r_q, dbz_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  // Decoded request (only meaningful while IDLE and start is high)
  logic             op_signed;
  logic [WIDTH-1:0] a_abs, b_abs, most_neg;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] result;

  assign most_neg  = {1'b1, {(WIDTH-1){1'b0}}};
  assign op_signed = ~div_op[0];
  assign a_abs     = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_abs     = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // Restoring step: trial subtract on the shifted partial remainder
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      FIN:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result selection; op_q[1] picks remainder, op_q[0] clear means signed
  always_comb begin
    result = '0;
    if (dbz_q) begin
      result = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      result = op_q[1] ? '0 : most_neg;
    end else if (op_q[1]) begin
      result = (!op_q[0] && sign_r_q) ? (~rem_q + 1'b1) : rem_q;
    end else begin
      result = (!op_q[0] && sign_q_q) ? (~quo_q + 1'b1) : quo_q;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      C        <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= div_op;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            a_q      <= A;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r_q <= op_signed & A[WIDTH-1];
            dbz_q    <= (B == '0);
            ovf_q    <= op_signed && (A == most_neg) && (B == '1);
          end
        end
        CALC: begin
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
          rem_q <= trial[WIDTH+1] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
        FIN: begin
          C    <= result;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
